// File: rtl/bcd_to_7seg_decoder.sv
// BCD digit to seven-segment decoder with lamp test, blanking and ripple blanking.
// Every output is registered, so a change on the inputs appears one clock later.
module bcd_to_7seg_decoder #(
   parameter bit ACTIVE_LOW   = 1'b0,
   parameter bit INVALID_DASH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd_input,
   input  logic       lamp_test,
   input  logic       blank,
   input  logic       rbi,
   output logic [6:0] seven_segment_output,
   output logic       rbo,
   output logic       invalid
);

   localparam logic [6:0] SEG_ALL  = 7'h7F;
   localparam logic [6:0] SEG_NONE = 7'h00;
   localparam logic [6:0] SEG_BAD  = INVALID_DASH ? 7'h40 : 7'h00;
   localparam logic [6:0] SEG_DARK = ACTIVE_LOW ? ~SEG_NONE : SEG_NONE;

   logic [6:0] digit_pat;
   logic [6:0] seg_pat;
   logic [6:0] seg_d, seg_q;
   logic       rbo_d, rbo_q;
   logic       invalid_d, invalid_q;

   // Segment order is {g,f,e,d,c,b,a}, written active-high.
   always_comb begin
      digit_pat = SEG_BAD;
      case (bcd_input)
         4'd0:    digit_pat = 7'h3F;
         4'd1:    digit_pat = 7'h06;
         4'd2:    digit_pat = 7'h5B;
         4'd3:    digit_pat = 7'h4F;
         4'd4:    digit_pat = 7'h66;
         4'd5:    digit_pat = 7'h6D;
         4'd6:    digit_pat = 7'h7D;
         4'd7:    digit_pat = 7'h07;
         4'd8:    digit_pat = 7'h7F;
         4'd9:    digit_pat = 7'h6F;
         default: digit_pat = SEG_BAD;
      endcase
   end

   always_comb begin
      seg_pat   = digit_pat;
      rbo_d     = 1'b0;
      invalid_d = (bcd_input > 4'd9);
      if (lamp_test) begin
         seg_pat = SEG_ALL;
      end else if (blank) begin
         seg_pat = SEG_NONE;
      end else if (rbi && (bcd_input == 4'd0)) begin
         // Leading zero suppressed; tell the next digit down the chain.
         seg_pat = SEG_NONE;
         rbo_d   = 1'b1;
      end
      seg_d = ACTIVE_LOW ? ~seg_pat : seg_pat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q     <= SEG_DARK;
         rbo_q     <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         seg_q     <= seg_d;
         rbo_q     <= rbo_d;
         invalid_q <= invalid_d;
      end
   end

   assign seven_segment_output = seg_q;
   assign rbo                  = rbo_q;
   assign invalid              = invalid_q;

endmodule

// File: tb/tb_bcd_to_7seg_decoder.sv
// Directed bench for bcd_to_7seg_decoder: default, common-anode and blank-invalid builds
// share one stimulus stream and are compared against hand-written patterns.
module tb_bcd_to_7seg_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] bcd_input;
   logic       lamp_test, blank, rbi;

   logic [6:0] seg_def, seg_al, seg_nd;
   logic       rbo_def, rbo_al, rbo_nd;
   logic       inv_def, inv_al, inv_nd;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] seg_tab [16];

   always #5 clk = ~clk;

   bcd_to_7seg_decoder dut (
      .clk(clk), .rst(rst), .bcd_input(bcd_input), .lamp_test(lamp_test),
      .blank(blank), .rbi(rbi), .seven_segment_output(seg_def),
      .rbo(rbo_def), .invalid(inv_def)
   );

   bcd_to_7seg_decoder #(.ACTIVE_LOW(1'b1), .INVALID_DASH(1'b1)) dut_al (
      .clk(clk), .rst(rst), .bcd_input(bcd_input), .lamp_test(lamp_test),
      .blank(blank), .rbi(rbi), .seven_segment_output(seg_al),
      .rbo(rbo_al), .invalid(inv_al)
   );

   bcd_to_7seg_decoder #(.ACTIVE_LOW(1'b0), .INVALID_DASH(1'b0)) dut_nd (
      .clk(clk), .rst(rst), .bcd_input(bcd_input), .lamp_test(lamp_test),
      .blank(blank), .rbi(rbi), .seven_segment_output(seg_nd),
      .rbo(rbo_nd), .invalid(inv_nd)
   );

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

      rst = 1'b1; bcd_input = 4'd8; lamp_test = 1'b0; blank = 1'b0; rbi = 1'b0;
      #3;
      chk("rst_seg",     seg_def, 7'h00);
      chk("rst_seg_al",  seg_al,  7'h7F);
      chk("rst_rbo",     7'(rbo_def), 7'd0);
      chk("rst_inv",     7'(inv_def), 7'd0);
      // Reset held across an edge must keep outputs dark.
      step();
      chk("rst_hold",    seg_def, 7'h00);
      chk("rst_hold_al", seg_al,  7'h7F);

      // First edge after release loads the current inputs.
      #3 rst = 1'b0; bcd_input = 4'd0;
      step();
      chk("first_seg", seg_def, 7'h3F);
      chk("first_rbo", 7'(rbo_def), 7'd0);
      chk("first_inv", 7'(inv_def), 7'd0);

      for (int i = 0; i < 16; i++) begin
         bcd_input = 4'(i);
         step();
         chk($sformatf("sweep_seg_%0d", i),    seg_def, seg_tab[i]);
         chk($sformatf("sweep_inv_%0d", i),    7'(inv_def), (i > 9) ? 7'd1 : 7'd0);
         chk($sformatf("sweep_seg_al_%0d", i), seg_al, ~seg_tab[i]);
         chk($sformatf("sweep_seg_nd_%0d", i), seg_nd, (i > 9) ? 7'h00 : seg_tab[i]);
         chk($sformatf("sweep_inv_nd_%0d", i), 7'(inv_nd), (i > 9) ? 7'd1 : 7'd0);
      end

      // Ripple blanking.
      bcd_input = 4'd0; rbi = 1'b1;
      step();
      chk("rbi0_seg",    seg_def, 7'h00);
      chk("rbi0_rbo",    7'(rbo_def), 7'd1);
      chk("rbi0_seg_al", seg_al,  7'h7F);
      chk("rbi0_rbo_al", 7'(rbo_al), 7'd1);
      bcd_input = 4'd5;
      step();
      chk("rbi5_seg", seg_def, 7'h6D);
      chk("rbi5_rbo", 7'(rbo_def), 7'd0);
      bcd_input = 4'd0; lamp_test = 1'b1;
      step();
      chk("rbi_lt_seg", seg_def, 7'h7F);
      chk("rbi_lt_rbo", 7'(rbo_def), 7'd0);
      lamp_test = 1'b0; blank = 1'b1;
      step();
      chk("rbi_bl_rbo", 7'(rbo_def), 7'd0);
      blank = 1'b0; rbi = 1'b0;

      // Lamp test beats blank.
      bcd_input = 4'd8; lamp_test = 1'b1; blank = 1'b1;
      step();
      chk("lt_bl_seg", seg_def, 7'h7F);
      lamp_test = 1'b0;
      step();
      chk("bl_seg", seg_def, 7'h00);
      blank = 1'b0;
      step();
      chk("eight_seg", seg_def, 7'h7F);

      // invalid ignores the overrides.
      bcd_input = 4'd12; lamp_test = 1'b1;
      step();
      chk("lt_inv_seg", seg_def, 7'h7F);
      chk("lt_inv",     7'(inv_def), 7'd1);
      lamp_test = 1'b0; blank = 1'b1; bcd_input = 4'd13;
      step();
      chk("bl_inv_seg", seg_def, 7'h00);
      chk("bl_inv",     7'(inv_def), 7'd1);
      blank = 1'b0; rbi = 1'b1; bcd_input = 4'd15;
      step();
      chk("rbi_inv", 7'(inv_def), 7'd1);
      rbi = 1'b0;

      // Common anode digit and invalid-blank build.
      bcd_input = 4'd1;
      step();
      chk("al_one", seg_al, 7'h79);
      bcd_input = 4'd12;
      step();
      chk("nd_twelve_seg", seg_nd, 7'h00);
      chk("nd_twelve_inv", 7'(inv_nd), 7'd1);
      chk("al_twelve_seg", seg_al, 7'h3F);

      // Mid-cycle reset while invalid is set.
      #2 rst = 1'b1;
      #1;
      chk("async_seg",    seg_def, 7'h00);
      chk("async_seg_al", seg_al,  7'h7F);
      chk("async_inv",    7'(inv_def), 7'd0);
      #2 rst = 1'b0; bcd_input = 4'd0; rbi = 1'b1;
      step();
      chk("post_rst_rbo", 7'(rbo_def), 7'd1);

      // Mid-cycle reset while rbo is set.
      #2 rst = 1'b1;
      #1;
      chk("async_rbo", 7'(rbo_def), 7'd0);
      #2 rst = 1'b0; rbi = 1'b0; bcd_input = 4'd3;
      step();
      chk("post_rst_seg", seg_def, 7'h4F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
